// File: rtl/sys_pll_supervisor.sv
// ---------------------------------------------------------------------------
// sys_pll_supervisor
//   Reset sequencer and lock supervisor for the system PLL (refclk domain).
//   Holds the PLL in reset, waits for a synchronized lock indication,
//   requires a run of stable lock before releasing downstream logic, retries
//   on lock timeout, and re-sequences the PLL when lock is lost in RUN.
//
// Ports
//   refclk        in   reference clock, sole clock of this block
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL lock indication, asynchronous to refclk
//   restart       in   synchronous soft-restart request (level or pulse)
//   pll_rst       out  active-high reset to the PLL
//   sys_ready     out  PLL stable, downstream logic may run
//   pll_fail      out  lock retries exhausted
//   retry_cnt     out  timeout retries used in the current attempt
//   lock_loss_cnt out  lock losses seen in RUN, saturating
//   state         out  0 RESET_HOLD, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN, 4 FAIL
// ---------------------------------------------------------------------------
module sys_pll_supervisor #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned CNT_W        = 8,
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             restart,
    output logic             pll_rst,
    output logic             sys_ready,
    output logic             pll_fail,
    output logic [RTY_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]       state
);

    localparam int unsigned TMAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned TMAX  = (TMAX0 > LOCK_STABLE) ? TMAX0 : LOCK_STABLE;
    localparam int unsigned TMR_W = $clog2(TMAX);

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(LOCK_STABLE - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABILIZE  = 3'd2,
        S_RUN        = 3'd3,
        S_FAIL       = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [CNT_W-1:0]   llc_q, llc_d;
    logic               sync1_q, sync2_q;
    logic               locked_s;
    logic               pll_rst_q, sys_ready_q, pll_fail_q;

    assign locked_s = sync2_q;

    // Next-state logic. restart overrides everything, including a lock loss
    // in RUN, so that case never reaches the lock-loss counter. The timer is
    // cleared on every transition and simply holds in RUN and FAIL.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        llc_d   = llc_q;
        if (restart) begin
            state_d = S_RESET_HOLD;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_RESET_HOLD: begin
                    if (timer_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = S_STABILIZE;
                        timer_d = '0;
                    end else if (timer_q == TMO_LAST) begin
                        timer_d = '0;
                        if (retry_q == RTY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_RESET_HOLD;
                            retry_d = retry_q + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_STABILIZE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STB_LAST) begin
                        state_d = S_RUN;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d = S_RESET_HOLD;
                        timer_d = '0;
                        if (llc_q != '1) begin
                            llc_d = llc_q + 1'b1;
                        end
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_RESET_HOLD;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they always match the
    // state register exactly.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= S_RESET_HOLD;
            timer_q     <= '0;
            retry_q     <= '0;
            llc_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_ready_q <= 1'b0;
            pll_fail_q  <= 1'b0;
        end else begin
            sync1_q     <= pll_locked;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            llc_q       <= llc_d;
            pll_rst_q   <= (state_d == S_RESET_HOLD) || (state_d == S_FAIL);
            sys_ready_q <= (state_d == S_RUN);
            pll_fail_q  <= (state_d == S_FAIL);
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_ready     = sys_ready_q;
    assign pll_fail      = pll_fail_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = llc_q;
    assign state         = state_q;

endmodule
